// File: rtl/kvs_pkg.sv
// Shared types for the key/value store: FSM states, decoded operations and LA_o debug layout.
package kvs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_SLOTRD = 2'd1,
        OP_INSERT = 2'd2,
        OP_DELETE = 2'd3
    } op_e;

    // LA_o = {state, idx, count} packed from bit 0 upward
    localparam int LA_CNT_LSB = 0;

    function automatic int la_idx_lsb(input int idx_w);
        return idx_w + 1;
    endfunction

    function automatic int la_st_lsb(input int idx_w);
        return 2 * idx_w + 1;
    endfunction

    function automatic op_e decode_op(input logic we, input logic adr_is_key,
                                      input logic dat_is_key);
        if (we) return dat_is_key ? OP_DELETE : OP_INSERT;
        return adr_is_key ? OP_LOOKUP : OP_SLOTRD;
    endfunction

endpackage

// File: rtl/keyvalue_store_if.sv
// Wishbone-classic style request/response bundle for keyvalue_store.
interface keyvalue_store_if #(
    parameter int KEY_W = 16,
    parameter int VAL_W = 16
);
    logic             STB_i;
    logic             CYC_i;
    logic             WE_i;
    logic             ADR_IS_KEY_i;
    logic             DAT_IS_KEY_i;
    logic [KEY_W-1:0] ADR_i;
    logic [VAL_W-1:0] DAT_i;
    logic [VAL_W-1:0] DAT_o;
    logic             DUP_o;
    logic             HIT_o;
    logic             ERR_o;
    logic             ACK_o;

    modport master (
        output STB_i, CYC_i, WE_i, ADR_IS_KEY_i, DAT_IS_KEY_i, ADR_i, DAT_i,
        input  DAT_o, DUP_o, HIT_o, ERR_o, ACK_o
    );

    modport slave (
        input  STB_i, CYC_i, WE_i, ADR_IS_KEY_i, DAT_IS_KEY_i, ADR_i, DAT_i,
        output DAT_o, DUP_o, HIT_o, ERR_o, ACK_o
    );
endinterface

// File: rtl/kvs_entry_array.sv
// Key/value/valid storage: one combinational indexed read port, one write-or-clear port.
module kvs_entry_array #(
    parameter int KEY_W = 16,
    parameter int VAL_W = 16,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [KEY_W-1:0] rd_key_o,
    output logic [VAL_W-1:0] rd_val_o,
    output logic             rd_vld_o,
    input  logic             wr_en_i,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [KEY_W-1:0] wr_key_i,
    input  logic [VAL_W-1:0] wr_val_i
);
    logic [DEPTH-1:0][KEY_W-1:0] key_q;
    logic [DEPTH-1:0][VAL_W-1:0] val_q;
    logic [DEPTH-1:0]            vld_q;
    logic                        in_range;

    // Only a non-power-of-two depth can be addressed past its last entry
    generate
        if (DEPTH == (1 << IDX_W)) begin : g_pow2
            assign in_range = 1'b1;
        end else begin : g_npow2
            assign in_range = (32'(rd_idx_i) < 32'(DEPTH));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (wr_en_i) begin
            vld_q[wr_idx_i] <= 1'b1;
        end else if (clr_i) begin
            vld_q[wr_idx_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            key_q[wr_idx_i] <= wr_key_i;
            val_q[wr_idx_i] <= wr_val_i;
        end
    end

    always_comb begin
        rd_key_o = '0;
        rd_val_o = '0;
        rd_vld_o = 1'b0;
        if (in_range) begin
            rd_key_o = key_q[rd_idx_i];
            rd_val_o = val_q[rd_idx_i];
            rd_vld_o = vld_q[rd_idx_i];
        end
    end
endmodule

// File: rtl/keyvalue_store.sv
// Associative key/value store with a linear-scan FSM behind a Wishbone-classic slave.
// Define KVS_OVERWRITE_EN to make an insert that hits an existing key replace its value.
module keyvalue_store
    import kvs_pkg::*;
#(
    parameter int KEY_W = 16,
    parameter int VAL_W = 16,
    parameter int DEPTH = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_1,
    keyvalue_store_if.slave        bus,
    output logic [$clog2(DEPTH):0] COUNT_o,
    output logic [31:0]            LA_o
);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam int LA_IDX_LSB = la_idx_lsb(IDX_W);
    localparam int LA_ST_LSB  = la_st_lsb(IDX_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [VAL_W-1:0] dat_q, dat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             free_seen_q, free_seen_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic [IDX_W-1:0] tgt_q, tgt_d;
    logic             act_wr_q, act_wr_d;
    logic             act_clr_q, act_clr_d;
    logic             act_inc_q, act_inc_d;
    logic             act_dec_q, act_dec_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [VAL_W-1:0] dat_o_q, dat_o_d;
    logic             hit_q, hit_d;
    logic             dup_q, dup_d;
    logic             err_q, err_d;

    logic [KEY_W-1:0] rd_key;
    logic [VAL_W-1:0] rd_val;
    logic             rd_vld;
    logic             wr_en, wr_clr;
    logic             req, match, free_now, last;

    kvs_entry_array #(
        .KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH), .IDX_W(IDX_W)
    ) u_array (
        .clk      (sys_clk),
        .rst_n    (sys_rst_1),
        .rd_idx_i (idx_q),
        .rd_key_o (rd_key),
        .rd_val_o (rd_val),
        .rd_vld_o (rd_vld),
        .wr_en_i  (wr_en),
        .clr_i    (wr_clr),
        .wr_idx_i (tgt_q),
        .wr_key_i (key_q),
        .wr_val_i (dat_q)
    );

    assign req      = bus.STB_i & bus.CYC_i;
    assign match    = rd_vld && (rd_key == key_q);
    assign free_now = !rd_vld;
    assign last     = (idx_q == LAST_IDX);

    always_ff @(posedge sys_clk or negedge sys_rst_1) begin
        if (!sys_rst_1) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOOKUP;
            key_q       <= '0;
            dat_q       <= '0;
            idx_q       <= '0;
            free_seen_q <= 1'b0;
            free_idx_q  <= '0;
            tgt_q       <= '0;
            act_wr_q    <= 1'b0;
            act_clr_q   <= 1'b0;
            act_inc_q   <= 1'b0;
            act_dec_q   <= 1'b0;
            count_q     <= '0;
            dat_o_q     <= '0;
            hit_q       <= 1'b0;
            dup_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            key_q       <= key_d;
            dat_q       <= dat_d;
            idx_q       <= idx_d;
            free_seen_q <= free_seen_d;
            free_idx_q  <= free_idx_d;
            tgt_q       <= tgt_d;
            act_wr_q    <= act_wr_d;
            act_clr_q   <= act_clr_d;
            act_inc_q   <= act_inc_d;
            act_dec_q   <= act_dec_d;
            count_q     <= count_d;
            dat_o_q     <= dat_o_d;
            hit_q       <= hit_d;
            dup_q       <= dup_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        key_d       = key_q;
        dat_d       = dat_q;
        idx_d       = idx_q;
        free_seen_d = free_seen_q;
        free_idx_d  = free_idx_q;
        tgt_d       = tgt_q;
        act_wr_d    = act_wr_q;
        act_clr_d   = act_clr_q;
        act_inc_d   = act_inc_q;
        act_dec_d   = act_dec_q;
        count_d     = count_q;
        dat_o_d     = dat_o_q;
        hit_d       = hit_q;
        dup_d       = dup_q;
        err_d       = err_q;
        wr_en       = 1'b0;
        wr_clr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d        = decode_op(bus.WE_i, bus.ADR_IS_KEY_i, bus.DAT_IS_KEY_i);
                    key_d       = bus.ADR_i;
                    dat_d       = bus.DAT_i;
                    free_seen_d = 1'b0;
                    free_idx_d  = '0;
                    idx_d       = (op_d == OP_SLOTRD) ? bus.ADR_i[IDX_W-1:0] : '0;
                    state_d     = ST_SCAN;
                end
            end

            ST_SCAN: begin
                // Results are registered on the way into RESP so they are valid alongside ACK
                if (op_q == OP_SLOTRD) begin
                    hit_d     = rd_vld;
                    dat_o_d   = rd_vld ? rd_val : '0;
                    dup_d     = 1'b0;
                    err_d     = 1'b0;
                    act_wr_d  = 1'b0;
                    act_clr_d = 1'b0;
                    act_inc_d = 1'b0;
                    act_dec_d = 1'b0;
                    state_d   = ST_RESP;
                end else begin
                    if (!free_seen_q && free_now) begin
                        free_seen_d = 1'b1;
                        free_idx_d  = idx_q;
                    end
                    if (match || last) begin
                        hit_d     = 1'b0;
                        dup_d     = 1'b0;
                        err_d     = 1'b0;
                        dat_o_d   = '0;
                        act_wr_d  = 1'b0;
                        act_clr_d = 1'b0;
                        act_inc_d = 1'b0;
                        act_dec_d = 1'b0;
                        tgt_d     = idx_q;
                        state_d   = ST_RESP;
                        case (op_q)
                            OP_LOOKUP: begin
                                hit_d   = match;
                                dat_o_d = match ? rd_val : '0;
                            end
                            OP_INSERT: begin
                                if (match) begin
                                    hit_d = 1'b1;
                                    dup_d = 1'b1;
`ifdef KVS_OVERWRITE_EN
                                    act_wr_d = 1'b1;
`endif
                                end else if (free_seen_q || free_now) begin
                                    act_wr_d  = 1'b1;
                                    act_inc_d = 1'b1;
                                    tgt_d     = free_seen_q ? free_idx_q : idx_q;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            OP_DELETE: begin
                                hit_d     = match;
                                act_clr_d = match;
                                act_dec_d = match;
                            end
                            default: ;
                        endcase
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            ST_RESP: begin
                wr_en     = act_wr_q;
                wr_clr    = act_clr_q;
                count_d   = count_q + {{IDX_W{1'b0}}, act_inc_q} - {{IDX_W{1'b0}}, act_dec_q};
                act_wr_d  = 1'b0;
                act_clr_d = 1'b0;
                act_inc_d = 1'b0;
                act_dec_d = 1'b0;
                state_d   = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.DAT_o = dat_o_q;
    assign bus.HIT_o = hit_q;
    assign bus.DUP_o = dup_q;
    assign bus.ERR_o = err_q;
    assign bus.ACK_o = (state_q == ST_RESP);
    assign COUNT_o   = count_q;

    always_comb begin
        LA_o = '0;
        LA_o[LA_CNT_LSB +: IDX_W+1] = count_q;
        LA_o[LA_IDX_LSB +: IDX_W]   = idx_q;
        LA_o[LA_ST_LSB +: 2]        = state_q;
    end
endmodule

// File: tb/tb_keyvalue_store.sv
// Directed bench for keyvalue_store (DEPTH=4) checked against a slot-table model every cycle.
module tb_keyvalue_store;
    localparam int DEPTH = 4;
    localparam int LOOKUP = 0, SLOTRD = 1, INSERT = 2, DELETE = 3;

    logic       clk = 1'b0;
    logic       sys_rst_1;
    logic [2:0] COUNT_o;
    logic [31:0] LA_o;

    keyvalue_store_if #(.KEY_W(16), .VAL_W(16)) bus ();

    keyvalue_store #(.KEY_W(16), .VAL_W(16), .DEPTH(DEPTH)) dut (
        .sys_clk   (clk),
        .sys_rst_1 (sys_rst_1),
        .bus       (bus),
        .COUNT_o   (COUNT_o),
        .LA_o      (LA_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tot = 0;
    int n_pass = 0;

    // Model: slot table, lowest matching slot wins, lowest free slot takes a new key
    logic [15:0] mk [DEPTH];
    logic [15:0] mv [DEPTH];
    bit          mvld [DEPTH];
    int          cnt_exp = 0;

    bit          pending = 0;
    int          issue_cyc, exp_ack_cyc, exp_lat, exp_delta;
    bit          exp_hit, exp_dup, exp_err, exp_chk_dat;
    logic [15:0] exp_dat;

    int          obs_lat;
    logic [15:0] obs_dat;
    logic        obs_hit, obs_dup, obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mvld[i] = 0;
            mk[i]   = '0;
            mv[i]   = '0;
        end
    endtask

    task automatic model(input int op, input logic [15:0] key, input logic [15:0] dat);
        int hit_i  = -1;
        int free_i = -1;
        int a;
        exp_hit = 0; exp_dup = 0; exp_err = 0; exp_dat = '0; exp_delta = 0; exp_chk_dat = 0;
        if (op == SLOTRD) begin
            a           = int'(key[1:0]);
            exp_lat     = 2;
            exp_hit     = mvld[a];
            exp_dat     = mvld[a] ? mv[a] : 16'h0;
            exp_chk_dat = 1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit_i < 0 && mvld[i] && mk[i] == key) hit_i = i;
                if (free_i < 0 && !mvld[i]) free_i = i;
            end
            exp_lat = (hit_i >= 0) ? hit_i + 2 : DEPTH + 1;
            if (op == LOOKUP) begin
                exp_chk_dat = 1;
                if (hit_i >= 0) begin
                    exp_hit = 1;
                    exp_dat = mv[hit_i];
                end
            end else if (op == INSERT) begin
                if (hit_i >= 0) begin
                    exp_hit = 1;
                    exp_dup = 1;
`ifdef KVS_OVERWRITE_EN
                    mv[hit_i] = dat;
`endif
                end else if (free_i >= 0) begin
                    mk[free_i]   = key;
                    mv[free_i]   = dat;
                    mvld[free_i] = 1;
                    exp_delta    = 1;
                end else begin
                    exp_err = 1;
                end
            end else if (hit_i >= 0) begin
                mvld[hit_i] = 0;
                exp_hit     = 1;
                exp_delta   = -1;
            end
        end
    endtask

    task automatic drive(input int op, input logic [15:0] key, input logic [15:0] dat);
        bus.STB_i        = 1'b1;
        bus.CYC_i        = 1'b1;
        bus.WE_i         = (op == INSERT || op == DELETE);
        bus.ADR_IS_KEY_i = (op == LOOKUP);
        bus.DAT_IS_KEY_i = (op == DELETE);
        bus.ADR_i        = key;
        bus.DAT_i        = dat;
    endtask

    task automatic release_bus();
        bus.STB_i = 1'b0;
        bus.CYC_i = 1'b0;
        bus.ADR_i = ~bus.ADR_i;
        bus.DAT_i = ~bus.DAT_i;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after ACK.
    task automatic do_op(input int op, input logic [15:0] key, input logic [15:0] dat);
        model(op, key, dat);
        drive(op, key, dat);
        issue_cyc   = cyc;
        exp_ack_cyc = cyc + exp_lat;
        pending     = 1;
        @(negedge clk);
        release_bus();
        for (int t = 0; t < 40 && pending; t++) @(posedge clk);
        if (pending) begin
            chk("ack_timeout", 32'd0, 32'd1);
            pending = 0;
        end
        @(negedge clk);
    endtask

    // Compare process: ACK timing and COUNT every cycle, status flags on every expected ACK
    initial begin
        bit ack_exp;
        forever begin
            @(negedge clk);
            ack_exp = pending && (cyc == exp_ack_cyc);
            chk("ack", {31'd0, bus.ACK_o}, {31'd0, ack_exp});
            chk("count", {29'd0, COUNT_o}, cnt_exp);
            if (bus.ACK_o) begin
                obs_lat = cyc - issue_cyc;
                obs_dat = bus.DAT_o;
                obs_hit = bus.HIT_o;
                obs_dup = bus.DUP_o;
                obs_err = bus.ERR_o;
            end
            if (ack_exp) begin
                chk("hit", {31'd0, bus.HIT_o}, {31'd0, exp_hit});
                chk("dup", {31'd0, bus.DUP_o}, {31'd0, exp_dup});
                chk("err", {31'd0, bus.ERR_o}, {31'd0, exp_err});
                if (exp_chk_dat) chk("dat", {16'd0, bus.DAT_o}, {16'd0, exp_dat});
                cnt_exp = cnt_exp + exp_delta;
                pending = 0;
            end
        end
    end

    initial begin
        sys_rst_1        = 1'b0;
        bus.STB_i        = 1'b0;
        bus.CYC_i        = 1'b0;
        bus.WE_i         = 1'b0;
        bus.ADR_IS_KEY_i = 1'b0;
        bus.DAT_IS_KEY_i = 1'b0;
        bus.ADR_i        = '0;
        bus.DAT_i        = '0;
        model_clear();

        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, bus.ACK_o}, 32'd0);
        chk("rst_dat", {16'd0, bus.DAT_o}, 32'd0);
        chk("rst_count", {29'd0, COUNT_o}, 32'd0);
        chk("rst_la", LA_o, 32'd0);
        chk("rst_hit", {31'd0, bus.HIT_o}, 32'd0);
        sys_rst_1 = 1'b1;
        @(negedge clk);

        do_op(INSERT, 16'h1234, 16'hBEEF);
        chk("t2_ins_lat", obs_lat, 32'd5);
        do_op(LOOKUP, 16'h1234, 16'h0000);
        chk("t2_lat", obs_lat, 32'd2);
        chk("t2_dat", {16'd0, obs_dat}, 32'hBEEF);
        chk("t2_hit", {31'd0, obs_hit}, 32'd1);
        chk("t2_dup", {31'd0, obs_dup}, 32'd0);

        do_op(INSERT, 16'h1234, 16'hCAFE);
        chk("t3_dup", {31'd0, obs_dup}, 32'd1);
        chk("t3_lat", obs_lat, 32'd2);
        do_op(LOOKUP, 16'h1234, 16'h0000);
`ifdef KVS_OVERWRITE_EN
        chk("t3_dat", {16'd0, obs_dat}, 32'hCAFE);
`else
        chk("t3_dat", {16'd0, obs_dat}, 32'hBEEF);
`endif
        chk("t3_count", {29'd0, COUNT_o}, 32'd1);

        do_op(INSERT, 16'h0001, 16'h1111);
        do_op(INSERT, 16'h0002, 16'h2222);
        do_op(INSERT, 16'h0003, 16'h3333);
        do_op(INSERT, 16'h0005, 16'h5005);
        chk("t4_err", {31'd0, obs_err}, 32'd1);
        chk("t4_lat", obs_lat, 32'd5);
        chk("t4_count", {29'd0, COUNT_o}, 32'd4);
        do_op(LOOKUP, 16'h0005, 16'h0000);
        chk("t4_hit", {31'd0, obs_hit}, 32'd0);
        chk("t4_dat", {16'd0, obs_dat}, 32'd0);

        do_op(DELETE, 16'h0001, 16'h0000);
        chk("t5_del_hit", {31'd0, obs_hit}, 32'd1);
        chk("t5_del_lat", obs_lat, 32'd3);
        do_op(INSERT, 16'h0055, 16'h5555);
        do_op(SLOTRD, 16'h0001, 16'h0000);
        chk("t5_dat", {16'd0, obs_dat}, 32'h5555);
        chk("t5_hit", {31'd0, obs_hit}, 32'd1);
        chk("t5_lat", obs_lat, 32'd2);
        chk("t5_count", {29'd0, COUNT_o}, 32'd4);
        chk("t5_la", LA_o, 32'h0000_000C);

        do_op(DELETE, 16'h0009, 16'h0000);
        chk("del_miss_hit", {31'd0, obs_hit}, 32'd0);
        do_op(LOOKUP, 16'h0003, 16'h0000);
        chk("last_slot_dat", {16'd0, obs_dat}, 32'h3333);
        chk("last_slot_lat", obs_lat, 32'd5);
        do_op(DELETE, 16'h0003, 16'h0000);
        do_op(SLOTRD, 16'h0003, 16'h0000);
        chk("slot_empty_hit", {31'd0, obs_hit}, 32'd0);

        // Reset in the middle of a full-length scan
        drive(LOOKUP, 16'h7777, 16'h0000);
        @(negedge clk);
        release_bus();
        @(posedge clk);
        #2;
        sys_rst_1 = 1'b0;
        model_clear();
        cnt_exp = 0;
        repeat (6) @(negedge clk);
        chk("t6_count", {29'd0, COUNT_o}, 32'd0);
        chk("t6_la", LA_o, 32'd0);
        sys_rst_1 = 1'b1;
        @(negedge clk);
        do_op(LOOKUP, 16'h1234, 16'h0000);
        chk("t6_hit", {31'd0, obs_hit}, 32'd0);
        chk("t6_lat", obs_lat, 32'd5);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
